// File: rtl/qkd_sifter.sv
// BB84 sifter: one qubit per cycle; key_valid at T+2+j (j = position of last needed match), fail at T+1+N_QUBITS.
// Backpressure: key_out/key_valid held in DONE until key_ack; start ignored outside IDLE.
module qkd_sifter #(
  parameter int N_QUBITS = 640,
  parameter int KEY_BITS = 128,
  parameter int IDX_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*N_QUBITS-1:0] qubit_in,
  input  logic [N_QUBITS-1:0]   bob_base,
  input  logic                  key_ack,
  output logic                  busy,
  output logic [KEY_BITS-1:0]   key_out,
  output logic                  key_valid,
  output logic                  fail,
  output logic [IDX_W-1:0]      sift_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_FAIL} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2*N_QUBITS-1:0] r_qubit;
  logic [N_QUBITS-1:0]   r_bob;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_cnt;
  logic [KEY_BITS-1:0]   r_key;
  logic                  w_match;
  logic                  w_key_full;
  logic                  w_last_pos;

  // Captured vectors shift down each SCAN cycle, so position r_idx always sits at bit 0.
  assign w_match    = (r_bob[0] == r_qubit[1]);
  assign w_key_full = w_match && (r_cnt == IDX_W'(KEY_BITS - 1));
  assign w_last_pos = (r_idx == IDX_W'(N_QUBITS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN: begin
        if (w_key_full)      w_next = S_DONE;
        else if (w_last_pos) w_next = S_FAIL;
      end
      S_DONE:  if (key_ack) w_next = S_IDLE;
      S_FAIL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_SCAN);
    key_valid = (r_state == S_DONE);
    fail      = (r_state == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qubit <= '0;
      r_bob   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_key   <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_qubit <= qubit_in;
      r_bob   <= bob_base;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_key   <= '0;
    end else if (r_state == S_SCAN) begin
      r_qubit <= r_qubit >> 2;
      r_bob   <= r_bob >> 1;
      r_idx   <= r_idx + 1'b1;
      if (w_match) begin
        r_cnt <= r_cnt + 1'b1;
        for (int k = 0; k < KEY_BITS; k++) begin
          if (r_cnt == IDX_W'(k)) r_key[k] <= r_qubit[0];
        end
      end
    end
  end

  assign key_out    = r_key;
  assign sift_count = r_cnt;

endmodule

// File: tb/tb_qkd_sifter.sv
// Randomized and directed bench for qkd_sifter against a queue-based sifting model.
module tb_qkd_sifter;

  localparam int N = 640;
  localparam int K = 128;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] qubit_in;
  logic [N-1:0]   bob_base;
  logic           key_ack;
  logic           busy;
  logic [K-1:0]   key_out;
  logic           key_valid;
  logic           fail;
  logic [W-1:0]   sift_count;

  int n_total = 0;
  int n_bad   = 0;

  qkd_sifter #(.N_QUBITS(N), .KEY_BITS(K), .IDX_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .qubit_in   (qubit_in),
    .bob_base   (bob_base),
    .key_ack    (key_ack),
    .busy       (busy),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .fail       (fail),
    .sift_count (sift_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: list every sifted bit with its position, then read the outcome off the list.
  task automatic model(input logic [2*N-1:0] qv, input logic [N-1:0] bb,
                       output bit done, output int j, output logic [K-1:0] key, output int cnt);
    bit sifted[$];
    int pos[$];
    for (int i = 0; i < N; i++) begin
      if (bb[i] == qv[2*i+1]) begin
        sifted.push_back(qv[2*i]);
        pos.push_back(i);
      end
    end
    done = (sifted.size() >= K);
    j    = done ? pos[K-1] : -1;
    cnt  = done ? K : sifted.size();
    key  = '0;
    for (int b = 0; b < cnt; b++) key[b] = sifted[b];
  endtask

  function automatic logic [2*N-1:0] rand_qv();
    logic [2*N-1:0] v;
    for (int w = 0; w < 2*N/32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [N-1:0] rand_bb();
    logic [N-1:0] v;
    for (int w = 0; w < N/32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [N-1:0] alice_bases(input logic [2*N-1:0] qv);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = qv[2*i+1];
    return v;
  endfunction

  // Returns at the negedge of cycle T+1, with the inputs already scrambled.
  task automatic start_run(input logic [2*N-1:0] qv, input logic [N-1:0] bb);
    @(negedge clk);
    qubit_in = qv;
    bob_base = bb;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    qubit_in = rand_qv();
    bob_base = rand_bb();
  endtask

  // Follows a run to DONE or to the IDLE cycle after FAIL; leaves the DUT in DONE when successful.
  task automatic scan_and_check(input string tag, input logic [2*N-1:0] qv, input logic [N-1:0] bb);
    bit           done;
    int           j, cnt;
    logic [K-1:0] key;
    int           first_kv = -1, first_fail = -1, fail_cnt = 0, busy_cnt = 0;
    model(qv, bb, done, j, key, cnt);
    start_run(qv, bb);
    for (int m = 0; m < 700; m++) begin
      if (busy) busy_cnt++;
      if (fail) begin
        fail_cnt++;
        if (first_fail < 0) first_fail = m;
      end
      if (key_valid) begin
        first_kv = m;
        break;
      end
      if (first_fail >= 0 && m == first_fail + 1) break;
      @(negedge clk);
    end
    check({tag, "_kv_cycle"},   K'(first_kv),   done ? K'(j + 1) : K'(-1));
    check({tag, "_fail_cycle"}, K'(first_fail), done ? K'(-1) : K'(N));
    check({tag, "_fail_width"}, K'(fail_cnt),   done ? K'(0) : K'(1));
    check({tag, "_busy_cycles"}, K'(busy_cnt),  done ? K'(j + 1) : K'(N));
    check({tag, "_key"},   key_out,        key);
    check({tag, "_count"}, K'(sift_count), K'(cnt));
  endtask

  task automatic ack_done(input string tag);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check({tag, "_kv_after_ack"}, K'(key_valid), K'(0));
  endtask

  initial begin
    logic [2*N-1:0] qv;
    logic [N-1:0]   bb;
    logic [K-1:0]   held_key;
    logic [W-1:0]   held_cnt;
    int             unstable, exp_cnt;

    rst = 1'b1; start = 1'b0; key_ack = 1'b0;
    qubit_in = '0; bob_base = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",  K'(busy),       K'(0));
    check("rst_kv",    K'(key_valid),  K'(0));
    check("rst_fail",  K'(fail),       K'(0));
    check("rst_key",   key_out,        K'(0));
    check("rst_count", K'(sift_count), K'(0));

    // Full match, alternating bits.
    qv = rand_qv();
    for (int i = 0; i < N; i++) qv[2*i] = i[0];
    scan_and_check("full", qv, alice_bases(qv));
    check("full_key_const", key_out, {(K/2){2'b10}});
    // Hold the key without ack, then ack together with start.
    held_key = key_out;
    held_cnt = sift_count;
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      if (key_out !== held_key || key_valid !== 1'b1 || sift_count !== held_cnt) unstable++;
      @(negedge clk);
    end
    check("hold_stable", K'(unstable), K'(0));
    start = 1'b1; key_ack = 1'b1; qubit_in = rand_qv(); bob_base = rand_bb();
    @(negedge clk);
    start = 1'b0; key_ack = 1'b0;
    check("hs_kv_drop", K'(key_valid), K'(0));
    unstable = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy !== 1'b0) unstable++;
      @(negedge clk);
    end
    check("hs_no_restart", K'(unstable),   K'(0));
    check("hs_key_kept",   key_out,        held_key);
    check("hs_count_kept", K'(sift_count), K'(held_cnt));

    // Total mismatch.
    qv = rand_qv();
    scan_and_check("mismatch", qv, ~alice_bases(qv));

    // Late boundary: 128 matches at 4, 9, ..., 639, all ones.
    qv = rand_qv();
    bb = ~alice_bases(qv);
    for (int k = 0; k < K; k++) begin
      bb[5*k+4] = qv[2*(5*k+4)+1];
      qv[2*(5*k+4)] = 1'b1;
    end
    scan_and_check("late", qv, bb);
    ack_done("late");

    // Short by one: drop the first of those matches.
    bb[4] = ~qv[9];
    scan_and_check("short", qv, bb);
    check("short_msb", K'(key_out[K-1]), K'(0));

    // Random runs, some biased towards failure.
    for (int r = 0; r < 6; r++) begin
      qv = rand_qv();
      bb = rand_bb();
      if (r >= 3) begin
        bb = ~alice_bases(qv);
        for (int i = 0; i < N; i++) if ($urandom_range(0, 4) == 0) bb[i] = qv[2*i+1];
      end
      scan_and_check($sformatf("rnd%0d", r), qv, bb);
      if (key_valid) ack_done($sformatf("rnd%0d", r));
    end

    // Start during SCAN is ignored, then reset aborts at T+50.
    qv = rand_qv();
    bb = rand_bb();
    exp_cnt = 0;
    for (int i = 0; i < 48; i++) if (bb[i] == qv[2*i+1]) exp_cnt++;
    start_run(qv, bb);
    for (int m = 0; m < 49; m++) begin
      start = (m >= 4 && m < 8);
      if (start) begin
        qubit_in = rand_qv();
        bob_base = rand_bb();
      end
      if (m == 48) begin
        check("ctl_busy",  K'(busy),       K'(1));
        check("ctl_count", K'(sift_count), K'(exp_cnt));
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  K'(busy),       K'(0));
    check("abort_kv",    K'(key_valid),  K'(0));
    check("abort_key",   key_out,        K'(0));
    check("abort_count", K'(sift_count), K'(0));
    repeat (2) @(negedge clk);
    check("abort_idle", K'(busy), K'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
